ifu_fetch_queue: RTL and testbench

- Instruction-fetch stage directly upstream of the decode stage.
- Holds the fetch PC and issues in-order word requests to instruction memory over a valid/ready request channel and a valid-only response channel.
- Buffers returned instructions with their PCs in a small FIFO and presents them to decode through a valid/ready handshake.
- Redirects from branch/jump resolution flush the buffer and drop stale in-flight responses.

---
 rtl/ifu_fetch_queue.sv | 116 +++++++++++
 tb/tb_ifu_fetch_queue.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch_queue.sv
// Instruction-fetch front end: issues in-order word fetches under a credit limit,
// buffers returned instructions with their PCs and hands them to decode.
module ifu_fetch_queue #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_o,
    output logic [63:0] pc_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [63:0]   fetch_pc;
    logic [63:0]   resp_pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] stale;
    logic [CW-1:0] fifo_count;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   inst_mem [DEPTH];
    logic [63:0]   pc_mem   [DEPTH];

    logic [CW+1:0] credit_used;
    logic          credit_ok;
    logic          fifo_empty;
    logic          req_fire;
    logic          resp_live;
    logic          resp_drop;
    logic          push;
    logic          pop;
    logic [63:0]   redirect_tgt;

    // Handshakes: a transfer happens on a cycle where valid && ready are both high
    // at the rising edge; valid never depends on ready. Responses have no ready.
    assign credit_used  = (CW+2)'(outstanding) + (CW+2)'(stale) + (CW+2)'(fifo_count);
    assign credit_ok    = credit_used < (CW+2)'(DEPTH);
    assign fifo_empty   = (fifo_count == '0);
    assign redirect_tgt = redirect_pc & ~64'h3;

    assign imem_req_valid = rst && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign resp_drop = imem_resp_valid && (stale != '0);
    assign resp_live = imem_resp_valid && (stale == '0);
    assign push      = resp_live && !redirect_valid;

    // A redirect hides the head so a same-cycle handshake never looks like a consume.
    assign inst_valid = !fifo_empty && !redirect_valid;
    assign pop        = inst_valid && inst_ready;
    assign inst_o     = fifo_empty ? 32'h0 : inst_mem[rd_ptr];
    assign pc_o       = fifo_empty ? 64'h0 : pc_mem[rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
            stale       <= '0;
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else if (redirect_valid) begin
            // Everything still in flight becomes stale; a response this cycle is
            // dropped, whichever counter it would have retired.
            fetch_pc    <= redirect_tgt;
            resp_pc     <= redirect_tgt;
            outstanding <= '0;
            stale       <= stale + outstanding - CW'(imem_resp_valid);
            fifo_count  <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            if (req_fire) begin
                fetch_pc <= fetch_pc + 64'd4;
            end
            outstanding <= outstanding + CW'(req_fire) - CW'(resp_live);
            stale       <= stale - CW'(resp_drop);
            if (push) begin
                resp_pc <= resp_pc + 64'd4;
                wr_ptr  <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            fifo_count <= fifo_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            inst_mem[wr_ptr] <= imem_resp_data;
            pc_mem[wr_ptr]   <= resp_pc;
        end
    end

`ifndef SYNTHESIS
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && fifo_count == CW'(DEPTH)));
    a_credit_bound: assert property (@(posedge clk) disable iff (!rst)
        credit_used <= (CW+2)'(DEPTH));
`endif

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// Directed bench for ifu_fetch_queue: memory model, decode driver, and a
// scoreboard that compares every instruction handed to decode.
module tb_ifu_fetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_o;
    logic [63:0] pc_o;

    always #5 clk = ~clk;

    ifu_fetch_queue #(
        .RESET_PC(64'h0000_0000_8000_0000),
        .DEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_o         (inst_o),
        .pc_o           (pc_o)
    );

    typedef struct {
        logic [63:0] addr;
        int          due;
    } pend_t;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [95:0] exp_q[$];
    pend_t       pend_q[$];
    int          cyc = 0;
    int          lat = 1;
    int          acc = 0;
    int          acc_lim = 0;
    bit          hold_ready = 1'b0;
    logic [95:0] mon_e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [63:0] pc, input logic [31:0] data);
        exp_q.push_back({pc, data});
    endtask

    // Memory: one response per accepted request, lat cycles later, data from address.
    initial begin
        pend_t p;
        imem_resp_valid = 1'b0;
        imem_resp_data  = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            imem_resp_valid = 1'b0;
            imem_resp_data  = 32'h0;
            if (!rst) begin
                pend_q.delete();
            end else if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                p = pend_q.pop_front();
                imem_resp_valid = 1'b1;
                imem_resp_data  = {p.addr[15:0], 16'h0013};
            end
            @(negedge clk);
            if (!rst) begin
                pend_q.delete();
            end else if (imem_req_valid && imem_req_ready) begin
                pend_q.push_back('{imem_req_addr, cyc + lat});
            end
        end
    end

    // Scoreboard monitor: every decode handshake must match the queue head.
    always @(negedge clk) begin
        if (rst && inst_valid && inst_ready && !redirect_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_inst: got pc %h inst %h expected none", pc_o, inst_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("inst_pc", pc_o, mon_e[95:32]);
                check("inst_data", 64'(inst_o), 64'(mon_e[31:0]));
            end
        end
    end

    task automatic begin_cycle();
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        imem_req_ready = !hold_ready && (acc < acc_lim);
    endtask

    task automatic end_cycle();
        @(negedge clk);
        if (rst && imem_req_valid && imem_req_ready) acc++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            begin_cycle();
            end_cycle();
        end
    endtask

    task automatic drain(input string name, input int max_cycles);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < max_cycles) begin
            run(1);
            k++;
        end
        check(name, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        run(4);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst            = 1'b0;
        inst_ready     = 1'b0;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        acc            = 0;
        hold_ready     = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 64'h0;
        inst_ready     = 1'b0;
        #1 rst = 1'b0;
        #1;
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_inst_valid", 64'(inst_valid), 64'd0);
        check("rst_inst_o", 64'(inst_o), 64'd0);
        check("rst_pc_o", pc_o, 64'd0);
        check("rst_req_addr", imem_req_addr, 64'h8000_0000);

        // Zero-wait memory, decode always ready.
        do_reset();
        lat = 1;
        acc_lim = 6;
        push_exp(64'h8000_0000, 32'h0000_0013);
        push_exp(64'h8000_0004, 32'h0004_0013);
        push_exp(64'h8000_0008, 32'h0008_0013);
        push_exp(64'h8000_000C, 32'h000C_0013);
        push_exp(64'h8000_0010, 32'h0010_0013);
        push_exp(64'h8000_0014, 32'h0014_0013);
        begin_cycle(); rst = 1'b1; inst_ready = 1'b1; end_cycle();
        check("a_first_req_valid", 64'(imem_req_valid), 64'd1);
        check("a_first_req_addr", imem_req_addr, 64'h8000_0000);
        check("a_c1_inst_valid", 64'(inst_valid), 64'd0);
        run(1);
        check("a_c2_inst_valid", 64'(inst_valid), 64'd0);
        run(1);
        check("a_c3_inst_valid", 64'(inst_valid), 64'd1);
        check("a_c3_pc", pc_o, 64'h8000_0000);
        check("a_c3_inst", 64'(inst_o), 64'h13);
        drain("a_drain", 40);

        // Decode stalled for five cycles: FIFO fills and requests stop.
        do_reset();
        lat = 1;
        acc_lim = 2;
        push_exp(64'h8000_0000, 32'h0000_0013);
        push_exp(64'h8000_0004, 32'h0004_0013);
        begin_cycle(); rst = 1'b1; end_cycle();
        run(2);
        run(1);
        check("b_c4_req_valid", 64'(imem_req_valid), 64'd0);
        run(1);
        check("b_c5_req_valid", 64'(imem_req_valid), 64'd0);
        check("b_c5_inst_valid", 64'(inst_valid), 64'd1);
        check("b_c5_pc", pc_o, 64'h8000_0000);
        begin_cycle(); inst_ready = 1'b1; end_cycle();
        drain("b_drain", 20);

        // Two requests in flight with latency 3, then a redirect.
        do_reset();
        lat = 3;
        acc_lim = 4;
        push_exp(64'h8000_1000, 32'h1000_0013);
        push_exp(64'h8000_1004, 32'h1004_0013);
        begin_cycle(); rst = 1'b1; inst_ready = 1'b1; end_cycle();
        run(1);
        begin_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_1002; end_cycle();
        check("c_redirect_req_valid", 64'(imem_req_valid), 64'd0);
        run(1);
        check("c_stale_block_req", 64'(imem_req_valid), 64'd0);
        run(1);
        check("c_new_req_valid", 64'(imem_req_valid), 64'd1);
        check("c_new_req_addr", imem_req_addr, 64'h8000_1000);
        drain("c_drain", 30);

        // Redirect in the same cycle as a response, one more still in flight.
        do_reset();
        lat = 2;
        acc_lim = 4;
        push_exp(64'h8000_2000, 32'h2000_0013);
        push_exp(64'h8000_2004, 32'h2004_0013);
        begin_cycle(); rst = 1'b1; inst_ready = 1'b1; end_cycle();
        run(1);
        begin_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_2000; end_cycle();
        run(1);
        check("d_new_req_valid", 64'(imem_req_valid), 64'd1);
        check("d_new_req_addr", imem_req_addr, 64'h8000_2000);
        drain("d_drain", 30);

        // Memory not ready for four cycles: request held stable.
        do_reset();
        lat = 1;
        acc_lim = 3;
        push_exp(64'h8000_0000, 32'h0000_0013);
        push_exp(64'h8000_0004, 32'h0004_0013);
        push_exp(64'h8000_0008, 32'h0008_0013);
        begin_cycle(); rst = 1'b1; inst_ready = 1'b1; end_cycle();
        run(2);
        hold_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            run(1);
            check("e_hold_req_valid", 64'(imem_req_valid), 64'd1);
            check("e_hold_req_addr", imem_req_addr, 64'h8000_0008);
        end
        hold_ready = 1'b0;
        run(1);
        check("e_release_req_valid", 64'(imem_req_valid), 64'd1);
        drain("e_drain", 20);

        // Redirect withdraws a pending request; target low bits are cleared.
        acc_lim = 4;
        push_exp(64'h8000_3004, 32'h3004_0013);
        begin_cycle(); redirect_valid = 1'b1; redirect_pc = 64'h0000_0000_8000_3007; end_cycle();
        check("f_redirect_withdraw", 64'(imem_req_valid), 64'd0);
        run(1);
        check("f_new_req_valid", 64'(imem_req_valid), 64'd1);
        check("f_new_req_addr", imem_req_addr, 64'h8000_3004);
        drain("f_drain", 20);

        // Asynchronous reset with two entries buffered.
        do_reset();
        lat = 1;
        acc_lim = 2;
        begin_cycle(); rst = 1'b1; end_cycle();
        run(3);
        check("g_buffered_valid", 64'(inst_valid), 64'd1);
        #2 rst = 1'b0;
        #1;
        check("g_async_inst_valid", 64'(inst_valid), 64'd0);
        check("g_async_req_valid", 64'(imem_req_valid), 64'd0);
        check("g_async_pc_o", pc_o, 64'd0);
        check("g_async_inst_o", 64'(inst_o), 64'd0);
        check("g_async_addr", imem_req_addr, 64'h8000_0000);
        repeat (2) @(negedge clk);
        acc = 0;
        acc_lim = 1;
        push_exp(64'h8000_0000, 32'h0000_0013);
        begin_cycle(); rst = 1'b1; inst_ready = 1'b1; end_cycle();
        check("g_restart_req_valid", 64'(imem_req_valid), 64'd1);
        check("g_restart_addr", imem_req_addr, 64'h8000_0000);
        drain("g_drain", 20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
